// File: rtl/uart_rx_framed.sv
// Framed asynchronous serial receiver: synchroniser, 3-sample majority vote,
// parity/framing/break detection and a first-word fall-through result FIFO.
module uart_rx_framed #(
    parameter int CLK_FREQ   = 10000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 iClk,
    input  logic                 iRst,
    input  logic                 iRx,
    input  logic                 iReady,
    input  logic                 iClr,
    output logic [DATA_BITS-1:0] oData,
    output logic                 oParityErr,
    output logic                 oFrameErr,
    output logic                 oValid,
    output logic                 oBreak,
    output logic                 oOverrun,
    output logic                 oBusy
);
    localparam int CLK_DIV = CLK_FREQ / BAUD;
    localparam int CNT_W   = $clog2(CLK_DIV) + 1;
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int EW      = DATA_BITS + 2;
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLK_DIV / 2);
    localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [3:0]       LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]       LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic [AW:0]      PTR_ONE   = (AW + 1)'(1);
    localparam logic             HAS_PARITY = (PARITY != 0);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } state_t;

    function automatic logic majority3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

    // Odd parity expects an odd count of ones over data plus parity bit.
    function automatic logic parity_mismatch(input logic [DATA_BITS-1:0] d, input logic p);
        logic x;
        x = (^d) ^ p;
        if (PARITY == 1) begin
            return ~x;
        end else if (PARITY == 2) begin
            return x;
        end else begin
            return 1'b0;
        end
    endfunction

    logic [1:0]           sync_r;
    logic [2:0]           samp_r;
    state_t               state_r, state_next;
    logic [CNT_W-1:0]     cnt_r, cnt_next;
    logic [3:0]           bit_cnt_r, bit_cnt_next;
    logic [DATA_BITS-1:0] shift_r, shift_next;
    logic                 par_err_r, par_err_next;
    logic                 par_bit_r, par_bit_next;
    logic                 stop_err_r, stop_err_next;
    logic                 stop0_r, stop0_next;
    logic                 push_s, brk_s, first_stop_s;
    logic                 fall_s, vote_s, tick_s;
    logic [EW-1:0]        entry_s;
    logic [EW-1:0]        mem_r [FIFO_DEPTH];
    logic [AW:0]          wr_ptr_r, rd_ptr_r;
    logic                 empty_s, full_s, pop_s, push_ok_s, drop_s;
    logic                 brk_r, ovr_r;
    logic [EW-1:0]        head_s;

    assign fall_s = samp_r[0] & ~sync_r[1];
    assign vote_s = majority3(samp_r);
    assign tick_s = (cnt_r == {CNT_W{1'b0}});

    // Input synchroniser and vote shift register, both idling high.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            sync_r <= 2'b11;
            samp_r <= 3'b111;
        end else begin
            sync_r <= {sync_r[0], iRx};
            samp_r <= {samp_r[1:0], sync_r[1]};
        end
    end

    // Receiver state and frame datapath registers.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            bit_cnt_r  <= 4'd0;
            shift_r    <= {DATA_BITS{1'b0}};
            par_err_r  <= 1'b0;
            par_bit_r  <= 1'b0;
            stop_err_r <= 1'b0;
            stop0_r    <= 1'b1;
        end else begin
            state_r    <= state_next;
            cnt_r      <= cnt_next;
            bit_cnt_r  <= bit_cnt_next;
            shift_r    <= shift_next;
            par_err_r  <= par_err_next;
            par_bit_r  <= par_bit_next;
            stop_err_r <= stop_err_next;
            stop0_r    <= stop0_next;
        end
    end

    // Next-state logic; every sample is CLK_DIV cycles after the previous one.
    always_comb begin
        state_next    = state_r;
        cnt_next      = cnt_r;
        bit_cnt_next  = bit_cnt_r;
        shift_next    = shift_r;
        par_err_next  = par_err_r;
        par_bit_next  = par_bit_r;
        stop_err_next = stop_err_r;
        stop0_next    = stop0_r;
        push_s        = 1'b0;
        brk_s         = 1'b0;
        first_stop_s  = 1'b1;
        case (state_r)
            ST_IDLE: begin
                if (fall_s) begin
                    state_next = ST_START;
                    cnt_next   = HALF_LOAD;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_START: begin
                if (tick_s) begin
                    cnt_next = BIT_LOAD;
                    if (vote_s) begin
                        state_next = ST_IDLE;
                    end else begin
                        state_next    = ST_DATA;
                        bit_cnt_next  = 4'd0;
                        par_err_next  = 1'b0;
                        par_bit_next  = 1'b0;
                        stop_err_next = 1'b0;
                    end
                end else begin
                    cnt_next = cnt_r - CNT_ONE;
                end
            end
            ST_DATA: begin
                if (tick_s) begin
                    cnt_next   = BIT_LOAD;
                    shift_next = {vote_s, shift_r[DATA_BITS-1:1]};
                    if (bit_cnt_r == LAST_DATA) begin
                        bit_cnt_next = 4'd0;
                        state_next   = HAS_PARITY ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_next = bit_cnt_r + 4'd1;
                    end
                end else begin
                    cnt_next = cnt_r - CNT_ONE;
                end
            end
            ST_PARITY: begin
                if (tick_s) begin
                    cnt_next     = BIT_LOAD;
                    par_bit_next = vote_s;
                    par_err_next = parity_mismatch(shift_r, vote_s);
                    bit_cnt_next = 4'd0;
                    state_next   = ST_STOP;
                end else begin
                    cnt_next = cnt_r - CNT_ONE;
                end
            end
            ST_STOP: begin
                if (tick_s) begin
                    cnt_next      = BIT_LOAD;
                    stop_err_next = stop_err_r | ~vote_s;
                    if (bit_cnt_r == 4'd0) begin
                        stop0_next = vote_s;
                    end else begin
                        stop0_next = stop0_r;
                    end
                    if (bit_cnt_r == LAST_STOP) begin
                        push_s       = 1'b1;
                        first_stop_s = (bit_cnt_r == 4'd0) ? vote_s : stop0_r;
                        brk_s        = (shift_r == {DATA_BITS{1'b0}}) &&
                                       (!HAS_PARITY || !par_bit_r) && !first_stop_s;
                        state_next   = stop_err_next ? ST_WAIT_IDLE : ST_IDLE;
                    end else begin
                        bit_cnt_next = bit_cnt_r + 4'd1;
                    end
                end else begin
                    cnt_next = cnt_r - CNT_ONE;
                end
            end
            ST_WAIT_IDLE: begin
                if (sync_r[1]) begin
                    state_next = ST_IDLE;
                end else begin
                    state_next = ST_WAIT_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign entry_s   = {shift_r, par_err_r, stop_err_next};
    assign empty_s   = (wr_ptr_r == rd_ptr_r);
    assign full_s    = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                       (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign pop_s     = ~empty_s & iReady;
    assign push_ok_s = push_s & (~full_s | pop_s);
    assign drop_s    = push_s & full_s & ~pop_s;
    assign head_s    = mem_r[rd_ptr_r[AW-1:0]];

    // FIFO pointers; the extra top bit separates full from empty.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            wr_ptr_r <= {(AW + 1){1'b0}};
            rd_ptr_r <= {(AW + 1){1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // FIFO storage; contents are masked at the outputs while empty.
    always_ff @(posedge iClk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= entry_s;
        end
    end

    // Break pulse and sticky overrun, where a drop beats a clear.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            brk_r <= 1'b0;
            ovr_r <= 1'b0;
        end else begin
            brk_r <= push_s & brk_s;
            if (drop_s) begin
                ovr_r <= 1'b1;
            end else if (iClr) begin
                ovr_r <= 1'b0;
            end
        end
    end

    // Head-of-FIFO presentation.
    always_comb begin
        if (empty_s) begin
            oData      = {DATA_BITS{1'b0}};
            oParityErr = 1'b0;
            oFrameErr  = 1'b0;
        end else begin
            oData      = head_s[EW-1:2];
            oParityErr = head_s[1];
            oFrameErr  = head_s[0];
        end
    end

    assign oValid   = ~empty_s;
    assign oBreak   = brk_r;
    assign oOverrun = ovr_r;
    assign oBusy    = (state_r != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_framed.sv
// Scoreboard bench: three receiver configurations (8N1, 8E1, 7N2) driven by
// a line model; expected entries come from an arithmetic frame model.
module tb_uart_rx_framed;
    localparam int BIT   = 10;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] rx, ready, clr;
    wire  [2:0] valid, brk, ovr, busy, pe, fe;
    wire  [7:0] d0, d1;
    wire  [6:0] d2;

    int checks = 0;
    int errors = 0;
    int vcyc[3];
    int nbrk[3];
    int exp_brk[3];
    int exp_ovr[3];
    logic [10:0] q0[$];
    logic [10:0] q1[$];
    logic [10:0] q2[$];

    always #5 clk = ~clk;

    uart_rx_framed #(.CLK_FREQ(10000000), .BAUD(1000000), .DATA_BITS(8), .PARITY(0),
                     .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dut_a (
        .iClk(clk), .iRst(rst), .iRx(rx[0]), .iReady(ready[0]), .iClr(clr[0]),
        .oData(d0), .oParityErr(pe[0]), .oFrameErr(fe[0]), .oValid(valid[0]),
        .oBreak(brk[0]), .oOverrun(ovr[0]), .oBusy(busy[0]));

    uart_rx_framed #(.CLK_FREQ(10000000), .BAUD(1000000), .DATA_BITS(8), .PARITY(2),
                     .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dut_b (
        .iClk(clk), .iRst(rst), .iRx(rx[1]), .iReady(ready[1]), .iClr(clr[1]),
        .oData(d1), .oParityErr(pe[1]), .oFrameErr(fe[1]), .oValid(valid[1]),
        .oBreak(brk[1]), .oOverrun(ovr[1]), .oBusy(busy[1]));

    uart_rx_framed #(.CLK_FREQ(10000000), .BAUD(1000000), .DATA_BITS(7), .PARITY(0),
                     .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) dut_c (
        .iClk(clk), .iRst(rst), .iRx(rx[2]), .iReady(ready[2]), .iClr(clr[2]),
        .oData(d2), .oParityErr(pe[2]), .oFrameErr(fe[2]), .oValid(valid[2]),
        .oBreak(brk[2]), .oOverrun(ovr[2]), .oBusy(busy[2]));

    function automatic int dbits(input int i);
        return (i == 2) ? 7 : 8;
    endfunction

    function automatic int pmode(input int i);
        return (i == 1) ? 2 : 0;
    endfunction

    function automatic int nstop(input int i);
        return (i == 2) ? 2 : 1;
    endfunction

    function automatic logic [8:0] dout(input int i);
        if (i == 0) return {1'b0, d0};
        else if (i == 1) return {1'b0, d1};
        else return {2'b00, d2};
    endfunction

    function automatic int qsize(input int i);
        if (i == 0) return q0.size();
        else if (i == 1) return q1.size();
        else return q2.size();
    endfunction

    // Frame model: returns {break, data[8:0], parity error, frame error}.
    function automatic logic [11:0] ref_entry(input int i, input logic [8:0] d,
                                              input logic pb, input logic [1:0] sb);
        int ones;
        logic perr, ferr, isbrk;
        ones = 0;
        for (int k = 0; k < dbits(i); k++) if (d[k]) ones++;
        if (pb) ones++;
        perr  = (pmode(i) == 1) ? (ones % 2 == 0) : (pmode(i) == 2) ? (ones % 2 == 1) : 1'b0;
        ferr  = !sb[0] || (nstop(i) == 2 && !sb[1]);
        isbrk = (d == 9'd0) && (pmode(i) == 0 || !pb) && !sb[0];
        return {isbrk, d, perr, ferr};
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic qpush(input int i, input logic [10:0] e);
        if (i == 0) q0.push_back(e);
        else if (i == 1) q1.push_back(e);
        else q2.push_back(e);
    endtask

    task automatic issue(input int i, input logic [8:0] d, input logic pb, input logic [1:0] sb);
        logic [11:0] r;
        r = ref_entry(i, d, pb, sb);
        if (r[11]) exp_brk[i]++;
        if (!ready[i] && qsize(i) >= DEPTH) exp_ovr[i] = 1;
        else qpush(i, r[10:0]);
    endtask

    task automatic drive(input int i, input logic v, input int cycles);
        rx[i] = v;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int i, input logic [8:0] d, input logic pb, input logic [1:0] sb);
        issue(i, d, pb, sb);
        drive(i, 1'b0, BIT);
        for (int k = 0; k < dbits(i); k++) drive(i, d[k], BIT);
        if (pmode(i) != 0) drive(i, pb, BIT);
        for (int k = 0; k < nstop(i); k++) drive(i, sb[k], BIT);
        drive(i, 1'b1, BIT);
    endtask

    task automatic pop_check(input int i, input logic [8:0] d, input logic p, input logic f);
        logic [10:0] e;
        if (qsize(i) == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_entry dut%0d: got data=%0h perr=%0b ferr=%0b expected none", i, d, p, f);
        end else begin
            if (i == 0) e = q0.pop_front();
            else if (i == 1) e = q1.pop_front();
            else e = q2.pop_front();
            chk($sformatf("data_dut%0d", i), int'(d), int'(e[10:2]));
            chk($sformatf("perr_dut%0d", i), int'(p), int'(e[1]));
            chk($sformatf("ferr_dut%0d", i), int'(f), int'(e[0]));
        end
    endtask

    // Monitor: checks each entry as it is consumed, counts pulses and valid cycles.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                if (brk[i]) nbrk[i]++;
                if (valid[i]) vcyc[i]++;
                if (valid[i] && ready[i]) pop_check(i, dout(i), pe[i], fe[i]);
            end
        end
    end

    // Directed scenarios followed by randomized frames on all three receivers.
    initial begin
        int vc, nb;
        logic [8:0] rd;
        logic [1:0] rs;
        logic rp;
        for (int i = 0; i < 3; i++) begin
            vcyc[i] = 0; nbrk[i] = 0; exp_brk[i] = 0; exp_ovr[i] = 0;
        end
        rst = 1'b1; rx = 3'b111; ready = 3'b111; clr = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_valid%0d", i), int'(valid[i]), 0);
            chk($sformatf("rst_busy%0d", i), int'(busy[i]), 0);
            chk($sformatf("rst_break%0d", i), int'(brk[i]), 0);
            chk($sformatf("rst_overrun%0d", i), int'(ovr[i]), 0);
            chk($sformatf("rst_flags%0d", i), int'({pe[i], fe[i]}), 0);
            chk($sformatf("rst_data%0d", i), int'(dout(i)), 0);
        end
        rst = 1'b0;
        drive(0, 1'b1, 5);

        // Clean 8N1 frame: one valid cycle, receiver idle afterwards.
        vc = vcyc[0];
        send_frame(0, 9'h0A5, 1'b0, 2'b11);
        chk("a5_valid_cycles", vcyc[0] - vc, 1);
        chk("a5_busy_after", int'(busy[0]), 0);

        // Short low glitch is a false start.
        vc = vcyc[0];
        drive(0, 1'b0, 3);
        drive(0, 1'b1, 3);
        chk("glitch_busy_high", int'(busy[0]), 1);
        drive(0, 1'b1, 12);
        chk("glitch_busy_low", int'(busy[0]), 0);
        chk("glitch_no_entry", vcyc[0] - vc, 0);
        send_frame(0, 9'h05A, 1'b0, 2'b11);

        // Fill the FIFO while stalled; the fifth frame overflows.
        ready[0] = 1'b0;
        for (int v = 1; v <= 5; v++) begin
            send_frame(0, 9'(v), 1'b0, 2'b11);
            if (v == 4) chk("ovr_after4", int'(ovr[0]), 0);
        end
        chk("ovr_after5", int'(ovr[0]), exp_ovr[0]);
        chk("full_valid", int'(valid[0]), 1);
        ready[0] = 1'b1;
        drive(0, 1'b1, BIT);
        chk("drained_valid", int'(valid[0]), 0);
        chk("ovr_sticky", int'(ovr[0]), 1);
        clr[0] = 1'b1;
        @(posedge clk);
        #1;
        clr[0] = 1'b0;
        exp_ovr[0] = 0;
        chk("ovr_cleared", int'(ovr[0]), exp_ovr[0]);

        // Line held low: one break entry, one pulse, then normal traffic.
        nb = nbrk[0];
        qpush(0, {9'h000, 1'b0, 1'b1});
        exp_brk[0]++;
        drive(0, 1'b0, 20 * BIT);
        drive(0, 1'b1, 3 * BIT);
        chk("break_pulses", nbrk[0] - nb, 1);
        chk("break_busy_after", int'(busy[0]), 0);
        send_frame(0, 9'h033, 1'b0, 2'b11);

        // Reset mid-frame drops the frame and the stored entry.
        ready[0] = 1'b0;
        send_frame(0, 9'h011, 1'b0, 2'b11);
        drive(0, 1'b0, BIT);
        for (int k = 0; k < 4; k++) drive(0, 1'b0, BIT);
        chk("midframe_busy", int'(busy[0]), 1);
        chk("midframe_valid", int'(valid[0]), 1);
        rx[0] = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q0.delete();
        chk("rst_mid_busy", int'(busy[0]), 0);
        chk("rst_mid_valid", int'(valid[0]), 0);
        chk("rst_mid_data", int'(dout(0)), 0);
        drive(0, 1'b1, 5 * BIT);
        chk("rst_mid_no_entry", int'(valid[0]), 0);
        ready[0] = 1'b1;
        send_frame(0, 9'h0C3, 1'b0, 2'b11);

        // Even parity: wrong and correct parity bit.
        send_frame(1, 9'h003, 1'b1, 2'b11);
        send_frame(1, 9'h003, 1'b0, 2'b11);

        // 7 data bits, 2 stop bits: clean, then second stop bit low.
        send_frame(2, 9'h07F, 1'b0, 2'b11);
        send_frame(2, 9'h07F, 1'b0, 2'b01);

        // Random frames including occasional zero data and bad stop bits.
        for (int n = 0; n < 10; n++) begin
            for (int i = 0; i < 3; i++) begin
                rd = (n % 4 == 3) ? 9'd0 : 9'($urandom_range(0, (1 << dbits(i)) - 1));
                rp = 1'($urandom_range(0, 1));
                rs = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
                send_frame(i, rd, rp, rs);
            end
        end

        drive(0, 1'b1, 3 * BIT);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("leftover_dut%0d", i), qsize(i), 0);
            chk($sformatf("breaks_dut%0d", i), nbrk[i], exp_brk[i]);
            chk($sformatf("overrun_dut%0d", i), int'(ovr[i]), exp_ovr[i]);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
